swd_switch_seq: RTL and testbench
=================================

// Module: swd_switch_seq
// PURPOSE
// - Sequences the JTAG-to-SWD switch on the target debug port: TMS/SWDIO line reset, 16-bit select pattern, idle cycles.
// - Sits between the trace register block (go/pattern/clk_div/done) and the target TCK/TMS pins.
// - Bit-bangs TCK from usb_clk by a programmable divider. Reports completion with a one-cycle done pulse.
// PARAMETERS
// - pPATTERN_BITS     16  width of select pattern, shifted LSB first
// - pLINE_RESET_BITS  56  TCK cycles with TMS=1 before and after the pattern (JTAG_LINE_RESET_EN only)
// - pIDLE_BITS         8  TCK cycles with TMS=0 after the final phase
// PORTS
// - usb_clk    in   1                  sole clock
// - reset_i    in   1                  synchronous, active-high reset
// - I_go       in   1                  level; start request, held high by register block until after O_done
// - I_pattern  in   pPATTERN_BITS      select pattern (default 16'he79e)
// - I_clk_div  in   8                  TCK half-period = I_clk_div+1 usb_clk cycles
// - O_tck      out  1                  target TCK/SWCLK; idles low
// - O_tms      out  1                  target TMS/SWDIO
// - O_busy     out  1                  high from go acceptance until DONE is entered
// - O_done     out  1                  one-cycle pulse at sequence end; feeds I_jtag_done of the register block
// BEHAVIOUR
// - Reset (any state, mid-sequence included): state=IDLE, O_tck=0, O_tms=1, O_busy=0, O_done=0, all counters 0.
// - FSM: IDLE -> PRE -> SHIFT -> POST -> IDLE_LOW -> DONE -> IDLE.
// - IDLE: on I_go=1, latch I_pattern and I_clk_div into shadow registers and enter PRE next cycle with O_busy=1.
// - Inputs changing after acceptance have no effect until the next sequence.
// - Bit timing: each TCK cycle is a low half then a high half, each (div+1) usb_clk cycles long.
// - O_tms updates only at the start of a low half; the target samples on the TCK rising edge.
// - First TCK rise is exactly div+1 cycles after PRE is entered.
// - PRE: pLINE_RESET_BITS TCK cycles, TMS=1.
// - SHIFT: pPATTERN_BITS cycles, TMS=pattern[i] for i=0..pPATTERN_BITS-1.
// - POST: pLINE_RESET_BITS cycles, TMS=1.
// - IDLE_LOW: pIDLE_BITS cycles, TMS=0.
// - Each phase ends after its last high half. The next phase's low half starts the following cycle, with no gap.
// - DONE: O_tck=0; O_tms holds last value (0); O_busy=0; O_done=1 for the first DONE cycle only.
// - DONE exits to IDLE only when I_go=0, so a go still high right after done cannot retrigger.
// - Counters: divider counts 0..div, so div=0 gives TCK=usb_clk/2 and div=255 gives /512. Bit counter is 7 bits, saturation-free; pLINE_RESET_BITS<=127.
// - Total usb_clk cycles from entering PRE to entering DONE = N_tck*2*(div+1).
// - N_tck = 2*pLINE_RESET_BITS+pPATTERN_BITS+pIDLE_BITS with JTAG_LINE_RESET_EN, else pPATTERN_BITS+pIDLE_BITS.
// - No abort input; reset_i is the only way to stop a running sequence.
// CONFIGURATION
// - Macro JTAG_LINE_RESET_EN defined: full sequence PRE/SHIFT/POST/IDLE_LOW.
// - Macro not defined: PRE and POST are skipped (IDLE -> SHIFT -> IDLE_LOW -> DONE); pLINE_RESET_BITS is unused.
// - Timing rules are identical in both builds.
// STRUCTURE
// - State encodings and the default-pattern constant go in defines_trace.v beside the register map.
// - One sub-module, swd_tck_gen: divider counter plus half-period tick, with rise/fall strobes and a phase enable.
// - The FSM, shadow registers, bit counter and pattern shifter stay in swd_switch_seq.
// TESTING
// - Macro on, div=0, pattern=16'he79e, go held: 136 TCK rises. TMS is 1 for rises 1-56.
// - Same run: rises 57-72 carry bits 0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,1. Rises 73-128 TMS=1, rises 129-136 TMS=0.
// - Same run: O_done pulses exactly 272 cycles after PRE entry.
// - Macro off, div=3, pattern=16'h0001: 24 TCK cycles of 8 usb_clk each. Only rise 1 has TMS=1. done after 192 cycles.
// - go held 5 cycles past done: no second sequence. Drop go, re-raise: new sequence starts; busy reasserts next cycle.
// - Change I_pattern and I_clk_div mid-SHIFT: shifted bits and TCK period still match the latched values.
// - reset_i during SHIFT bit 7: next cycle O_tck=0, O_tms=1, O_busy=0, no done pulse. A later go runs a full, correct sequence.

Source files
------------

// File: rtl/swd_switch_seq_pkg.sv
// Shared types and constants for the JTAG-to-SWD switch sequencer.
// State encodings, default phase lengths and the default select pattern.
package swd_switch_seq_pkg;

    localparam int          P_PATTERN_BITS    = 16;
    localparam int          P_LINE_RESET_BITS = 56;
    localparam int          P_IDLE_BITS       = 8;
    localparam logic [15:0] P_DEFAULT_PATTERN = 16'he79e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_POST     = 3'd3,
        ST_IDLE_LOW = 3'd4,
        ST_DONE     = 3'd5
    } swd_state_e;

endpackage

// File: rtl/swd_switch_seq_tck_gen.sv
// TCK generator: divider counter with a half-period toggle and a bit-end strobe.
// While disabled it holds TCK low with the divider cleared, so enabling starts a low half.
module swd_switch_seq_tck_gen (
    input  logic       usb_clk,
    input  logic       reset_i,
    input  logic       i_en,
    input  logic [7:0] i_div,
    output logic       o_tck,
    output logic       o_fall
);

    logic [7:0] r_cnt;
    logic       r_high;
    logic       w_wrap;

    assign w_wrap = i_en && (r_cnt == i_div);
    // Last cycle of a high half: the bit ends and the next low half starts next cycle.
    assign o_fall = w_wrap && r_high;
    assign o_tck  = r_high;

    always_ff @(posedge usb_clk) begin
        if (reset_i || !i_en) begin
            r_cnt  <= 8'd0;
            r_high <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= 8'd0;
            r_high <= ~r_high;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/swd_switch_seq.sv
// JTAG-to-SWD switch sequencer: line reset, 16-bit select pattern, idle cycles on TCK/TMS.
// Define JTAG_LINE_RESET_EN to include the PRE/POST line-reset phases around the pattern.
module swd_switch_seq
    import swd_switch_seq_pkg::*;
#(
    parameter int pPATTERN_BITS    = P_PATTERN_BITS,
    parameter int pLINE_RESET_BITS = P_LINE_RESET_BITS,
    parameter int pIDLE_BITS       = P_IDLE_BITS
) (
    input  logic                     usb_clk,
    input  logic                     reset_i,
    input  logic                     I_go,
    input  logic [pPATTERN_BITS-1:0] I_pattern,
    input  logic [7:0]               I_clk_div,
    output logic                     O_tck,
    output logic                     O_tms,
    output logic                     O_busy,
    output logic                     O_done,
    output logic [2:0]               O_dbg_state
);

    swd_state_e                r_state;
    swd_state_e                w_next;
    logic [pPATTERN_BITS-1:0]  r_shift;
    logic [7:0]                r_div;
    logic [6:0]                r_bit;
    logic                      r_tms;
    logic                      r_done;
    logic                      w_tck_en;
    logic                      w_step;
    logic                      w_phase_last;
    logic [6:0]                w_last_idx;
    logic                      w_tms_next;
    logic                      w_accept;

    swd_switch_seq_tck_gen u_tck_gen (
        .usb_clk (usb_clk),
        .reset_i (reset_i),
        .i_en    (w_tck_en),
        .i_div   (r_div),
        .o_tck   (O_tck),
        .o_fall  (w_step)
    );

    assign w_tck_en = (r_state == ST_PRE) || (r_state == ST_SHIFT) ||
                      (r_state == ST_POST) || (r_state == ST_IDLE_LOW);
    assign w_accept = (r_state == ST_IDLE) && I_go;
    assign w_phase_last = (r_bit == w_last_idx);

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_last_idx = 7'd0;
        w_tms_next = r_tms;
        case (r_state)
            ST_IDLE: begin
`ifdef JTAG_LINE_RESET_EN
                if (I_go) w_next = ST_PRE;
`else
                if (I_go) w_next = ST_SHIFT;
`endif
            end
            ST_PRE: begin
                w_last_idx = 7'(pLINE_RESET_BITS - 1);
                w_tms_next = w_phase_last ? r_shift[0] : 1'b1;
                if (w_step && w_phase_last) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_last_idx = 7'(pPATTERN_BITS - 1);
`ifdef JTAG_LINE_RESET_EN
                w_tms_next = w_phase_last ? 1'b1 : r_shift[1];
                if (w_step && w_phase_last) w_next = ST_POST;
`else
                w_tms_next = w_phase_last ? 1'b0 : r_shift[1];
                if (w_step && w_phase_last) w_next = ST_IDLE_LOW;
`endif
            end
            ST_POST: begin
                w_last_idx = 7'(pLINE_RESET_BITS - 1);
                w_tms_next = !w_phase_last;
                if (w_step && w_phase_last) w_next = ST_IDLE_LOW;
            end
            ST_IDLE_LOW: begin
                w_last_idx = 7'(pIDLE_BITS - 1);
                w_tms_next = 1'b0;
                if (w_step && w_phase_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                // Wait for go to drop so a still-high request cannot restart us.
                if (!I_go) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_shift <= '0;
            r_div   <= 8'd0;
            r_bit   <= 7'd0;
            r_tms   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_IDLE_LOW) && (w_next == ST_DONE);
            if (w_accept) begin
                r_shift <= I_pattern;
                r_div   <= I_clk_div;
                r_bit   <= 7'd0;
`ifdef JTAG_LINE_RESET_EN
                r_tms   <= 1'b1;
`else
                r_tms   <= I_pattern[0];
`endif
            end else if (w_tck_en && w_step) begin
                // TMS changes together with the TCK falling edge, i.e. at the start of a low half.
                r_tms <= w_tms_next;
                r_bit <= w_phase_last ? 7'd0 : r_bit + 7'd1;
                if (r_state == ST_SHIFT) r_shift <= r_shift >> 1;
            end
        end
    end

    assign O_tms       = r_tms;
    assign O_busy      = w_tck_en;
    assign O_done      = r_done;
    assign O_dbg_state = r_state;

endmodule

// File: tb/tb_swd_switch_seq.sv
// Self-checking bench for swd_switch_seq; expectations follow JTAG_LINE_RESET_EN if defined.
module tb_swd_switch_seq;
    import swd_switch_seq_pkg::*;

`ifdef JTAG_LINE_RESET_EN
    localparam int LINE = 56;
`else
    localparam int LINE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        go;
    logic [15:0] pattern;
    logic [7:0]  div;
    logic        tck, tms, busy, done;
    logic [2:0]  dbg_state;

    logic [0:0]  exp_q[$];
    int          exp_t_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    swd_switch_seq dut (
        .usb_clk     (clk),
        .reset_i     (reset_i),
        .I_go        (go),
        .I_pattern   (pattern),
        .I_clk_div   (div),
        .O_tck       (tck),
        .O_tms       (tms),
        .O_busy      (busy),
        .O_done      (done),
        .O_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic run_seq(input logic [15:0] pat, input logic [7:0] d,
                           input bit mid_change, input int abort_rise);
        int n_tck, per, rises;
        bit prev, finished, aborted;
        exp_q.delete();
        exp_t_q.delete();
        for (int i = 0; i < LINE; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(pat[i]);
        for (int i = 0; i < LINE; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        n_tck = exp_q.size();
        per = 2 * (int'(d) + 1);
        for (int k = 0; k < n_tck; k++) exp_t_q.push_back(int'(d) + 1 + k * per);

        @(negedge clk);
        pattern = pat;
        div = d;
        go = 1'b1;
        @(negedge clk);
        chk("busy_on", busy, 1);
        rises = 0;
        prev = 1'b0;
        finished = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c <= n_tck * per + 10; c++) begin
            if (c > 0) @(negedge clk);
            if (tck && !prev) begin
                rises++;
                if (exp_q.size() == 0) begin
                    chk("extra_rise", rises, n_tck);
                end else begin
                    chk("tms_bit", tms, exp_q.pop_front());
                    chk("rise_time", c, exp_t_q.pop_front());
                end
                if (rises - 1 == abort_rise) begin
                    reset_i = 1'b1;
                    go = 1'b0;
                    @(negedge clk);
                    chk("rst_tck", tck, 0);
                    chk("rst_tms", tms, 1);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    reset_i = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        chk("rst_no_done", done, 0);
                        chk("rst_idle_state", dbg_state, ST_IDLE);
                    end
                    finished = 1'b1;
                    aborted = 1'b1;
                end
            end
            if (!aborted && mid_change && c == (LINE + 4) * per) begin
                pattern = ~pat;
                div = d + 8'd3;
            end
            if (!aborted && done) begin
                chk("done_time", c, n_tck * per);
                finished = 1'b1;
            end
            prev = tck;
            if (finished) break;
        end
        if (!finished) chk("done_timeout", 0, 1);
        if (!aborted) begin
            chk("rise_count", rises, n_tck);
            chk("q_empty", exp_q.size(), 0);
            chk("done_state", dbg_state, ST_DONE);
            repeat (5) begin
                @(negedge clk);
                chk("post_done", done, 0);
                chk("post_busy", busy, 0);
                chk("post_tck", tck, 0);
                chk("post_tms", tms, 0);
            end
            go = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("back_idle", dbg_state, ST_IDLE);
        end
        exp_q.delete();
        exp_t_q.delete();
    endtask

    initial begin
        reset_i = 1'b1;
        go = 1'b0;
        pattern = P_DEFAULT_PATTERN;
        div = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_tck", tck, 0);
        chk("reset_tms", tms, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_state", dbg_state, ST_IDLE);
        reset_i = 1'b0;
        @(negedge clk);

        run_seq(16'he79e, 8'd0, 1'b0, -1);
        run_seq(16'h0001, 8'd3, 1'b0, -1);
        run_seq(16'($urandom), 8'($urandom_range(0, 4)), 1'b1, -1);
        run_seq(16'($urandom), 8'd1, 1'b0, LINE + 7);
        run_seq(16'he79e, 8'd2, 1'b0, -1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
